// File: rtl/decompressor_feeder.sv
// decompressor_feeder: parses a compressed byte stream into items for
// decompressor_top. A stream is a sequence of groups: one control byte
// followed by up to eight items, flag bit 7 first. A literal item (flag 0)
// is one byte presented as {8'h00, b0}. A copy item (flag 1) is two bytes
// presented as {b0, b1}.
//
// Handshakes:
//   Input side: in_valid/in_ready. A byte moves on a rising edge where both
//   are 1. in_ready depends only on the FSM state, never on in_valid.
//   Output side: data_in_valid/decompressor_busy. An item is accepted on a
//   rising edge where data_in_valid = 1 and decompressor_busy = 0. Until that
//   edge, data_in and control_word_in hold steady. After acceptance,
//   data_in_valid drops for at least one cycle. It stays low until busy is
//   seen low again, so the same item is never offered twice.
module decompressor_feeder #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [15:0]            data_in,
  output logic                   control_word_in,
  output logic                   data_in_valid,
  input  logic                   decompressor_busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] items_issued,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_CW   = 3'd1,
    GET_B0   = 3'd2,
    GET_B1   = 3'd3,
    ISSUE    = 3'd4,
    WAIT_ACK = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t state;
  state_t state_next;

  // Control byte shifted left after each item, so bit 7 is always the
  // flag of the item currently being parsed.
  logic [7:0] cw_reg;
  logic [2:0] item_idx;
  logic [7:0] b0_reg;
  logic       last_item;

  // Strobes from the FSM decode to the datapath registers.
  logic start_ok;
  logic cw_load;
  logic b0_load;
  logic lit_load;
  logic copy_load;
  logic set_err;
  logic accept;
  logic step_item;

  assign state_dbg = state;

  // State register: asynchronous active-low reset returns to IDLE at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; all outputs and strobes default low.
  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    data_in_valid = 1'b0;
    done          = 1'b0;
    start_ok      = 1'b0;
    cw_load       = 1'b0;
    b0_load       = 1'b0;
    lit_load      = 1'b0;
    copy_load     = 1'b0;
    set_err       = 1'b0;
    accept        = 1'b0;
    step_item     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = GET_CW;
        end
      end
      GET_CW: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cw_load = 1'b1;
          // A control byte that ends the stream issues nothing.
          state_next = in_last ? DONE : GET_B0;
        end
      end
      GET_B0: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cw_reg[7]) begin
            if (in_last) begin
              // Copy item cut off after its first byte: a truncated stream.
              set_err    = 1'b1;
              state_next = DONE;
            end else begin
              b0_load    = 1'b1;
              state_next = GET_B1;
            end
          end else begin
            lit_load   = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      GET_B1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          copy_load  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        data_in_valid = 1'b1;
        if (!decompressor_busy) begin
          accept     = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!decompressor_busy) begin
          if (last_item) begin
            state_next = DONE;
          end else if (item_idx == 3'd7) begin
            state_next = GET_CW;
          end else begin
            step_item  = 1'b1;
            state_next = GET_B0;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Group bookkeeping: current control byte and item position in the group.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cw_reg   <= 8'h00;
      item_idx <= 3'd0;
    end else if (cw_load) begin
      cw_reg   <= in_byte;
      item_idx <= 3'd0;
    end else if (step_item) begin
      cw_reg   <= {cw_reg[6:0], 1'b0};
      item_idx <= item_idx + 3'd1;
    end
  end

  // Item assembly: the registered item stays stable for the whole ISSUE state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b0_reg          <= 8'h00;
      data_in         <= 16'h0000;
      control_word_in <= 1'b0;
      last_item       <= 1'b0;
    end else begin
      if (start_ok) begin
        last_item <= 1'b0;
      end
      if (b0_load) begin
        b0_reg <= in_byte;
      end
      if (lit_load) begin
        data_in         <= {8'h00, in_byte};
        control_word_in <= 1'b0;
        last_item       <= in_last;
      end
      if (copy_load) begin
        data_in         <= {b0_reg, in_byte};
        control_word_in <= 1'b1;
        last_item       <= in_last;
      end
    end
  end

  // Status: sticky truncation flag and accepted-item counter, both cleared
  // when a new stream is armed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error        <= 1'b0;
      items_issued <= '0;
    end else begin
      if (start_ok) begin
        error        <= 1'b0;
        items_issued <= '0;
      end
      if (set_err) begin
        error <= 1'b1;
      end
      if (accept) begin
        items_issued <= items_issued + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_decompressor_feeder.sv
// Bench for decompressor_feeder: directed and random streams. A reference
// parser pushes expected items into a queue, and a monitor pops them as the
// decompressor model accepts items.
module tb_decompressor_feeder;

  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [15:0]   data_in;
  logic          control_word_in;
  logic          data_in_valid;
  logic          decompressor_busy = 1'b0;
  logic          done;
  logic          error;
  logic [CW-1:0] items_issued;
  logic [2:0]    state_dbg;

  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];
  int busy_pct = 0;
  int hold_first = 0;
  int hold_cnt = 0;
  bit busy_force = 1'b0;
  int done_cnt = 0;
  int acc_cnt = 0;

  decompressor_feeder #(.COUNT_WIDTH(CW)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .data_in(data_in),
    .control_word_in(control_word_in),
    .data_in_valid(data_in_valid),
    .decompressor_busy(decompressor_busy),
    .done(done),
    .error(error),
    .items_issued(items_issued),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference parser: walks the byte list group by group and queues items.
  function automatic void model(input logic [7:0] b[$], output int cnt, output bit err);
    int i;
    int n;
    logic [7:0] cw;
    logic [16:0] item;
    bit stop;
    n = b.size();
    i = 0;
    cnt = 0;
    err = 1'b0;
    stop = 1'b0;
    while (i < n && !stop) begin
      cw = b[i];
      i++;
      if (i == n) stop = 1'b1;
      for (int k = 0; k < 8 && !stop; k++) begin
        if (cw[7-k]) begin
          if (i == n - 1) begin
            err = 1'b1;
            stop = 1'b1;
          end else begin
            item = {1'b1, b[i], b[i+1]};
            i += 2;
            exp_q.push_back(item);
            cnt++;
          end
        end else begin
          item = {1'b0, 8'h00, b[i]};
          i += 1;
          exp_q.push_back(item);
          cnt++;
        end
        if (i == n) stop = 1'b1;
      end
    end
  endfunction

  // Decompressor model plus monitor: drives busy, compares accepted items.
  initial begin
    bit prev_acc;
    bit prev_stall;
    bit in_hold;
    logic [16:0] prev_item;
    logic [16:0] got;
    prev_acc = 1'b0;
    prev_stall = 1'b0;
    prev_item = '0;
    forever begin
      @(negedge clock);
      in_hold = 1'b0;
      if (busy_force) begin
        decompressor_busy = 1'b1;
      end else if (hold_cnt > 0) begin
        decompressor_busy = 1'b1;
        hold_cnt--;
        in_hold = 1'b1;
      end else begin
        decompressor_busy = ($urandom_range(99) < busy_pct);
      end
      #1;
      if (!reset) begin
        prev_acc = 1'b0;
        prev_stall = 1'b0;
      end else begin
        got = {control_word_in, data_in};
        if (done) done_cnt++;
        if (prev_acc) check("gap_after_accept", {31'd0, data_in_valid}, 32'd0);
        if (in_hold) check("valid_while_busy_hold", {31'd0, data_in_valid}, 32'd0);
        if (prev_stall && data_in_valid) check("item_stable", {15'd0, got}, {15'd0, prev_item});
        prev_acc = 1'b0;
        prev_stall = 1'b0;
        if (data_in_valid && !decompressor_busy) begin
          prev_acc = 1'b1;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_item: got=%0h expected=none", got);
          end else begin
            check("item", {15'd0, got}, {15'd0, exp_q.pop_front()});
          end
          if (acc_cnt == 0 && hold_first > 0) hold_cnt = hold_first;
          acc_cnt++;
        end else if (data_in_valid) begin
          prev_stall = 1'b1;
          prev_item = got;
        end
      end
    end
  end

  // Driver: arms the feeder, streams the bytes, then checks the stream end.
  task automatic run_stream(input string tag, input logic [7:0] s[$], input int vmode,
                            input bit mid_start);
    int n;
    int idx;
    int cyc;
    int exp_cnt;
    bit exp_err;
    bit v;
    bit xfer;
    n = s.size();
    model(s, exp_cnt, exp_err);
    done_cnt = 0;
    acc_cnt = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_start_clears_error"}, {31'd0, error}, 32'd0);
    check({tag, "_start_clears_count"}, {16'd0, items_issued}, 32'd0);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 3000) begin
      case (vmode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = ($urandom_range(1) == 1);
      endcase
      in_valid = v;
      in_byte = s[idx];
      in_last = (idx == n - 1);
      start = mid_start && (idx == 2);
      xfer = v && in_ready;
      @(negedge clock);
      if (xfer) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
    check({tag, "_bytes_consumed"}, idx, n);
    cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      @(negedge clock);
      #2;
      cyc++;
    end
    repeat (4) @(negedge clock);
    #2;
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    check({tag, "_items_issued"}, {16'd0, items_issued}, exp_cnt);
    check({tag, "_accepted"}, acc_cnt, exp_cnt);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Main sequence
  initial begin
    logic [7:0] s[$];
    logic [7:0] cw;
    int ng;
    int len;

    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_valid", {31'd0, data_in_valid}, 32'd0);
    check("rst_ctl", {31'd0, control_word_in}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_data", {16'd0, data_in}, 32'd0);
    check("rst_count", {16'd0, items_issued}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Literal then copy, ending on the copy's second byte.
    s = '{8'h40, 8'h61, 8'h00, 8'h05};
    run_stream("basic", s, 0, 1'b0);

    // Busy stays high for five cycles after the first acceptance.
    hold_first = 5;
    run_stream("busy_hold", s, 0, 1'b0);
    hold_first = 0;

    // Copy item truncated after b0.
    s = '{8'h80, 8'h12};
    run_stream("truncated", s, 0, 1'b0);

    // Three full groups, alternating copy/literal, toggling valid, stray start.
    s = '{};
    for (int g = 0; g < 3; g++) begin
      s.push_back(8'hAA);
      for (int k = 0; k < 8; k++) begin
        if (k % 2 == 0) begin
          s.push_back(8'($urandom));
          s.push_back(8'($urandom));
        end else begin
          s.push_back(8'($urandom));
        end
      end
    end
    run_stream("three_groups", s, 1, 1'b1);

    // Control byte carrying in_last issues nothing.
    s = '{8'hFF};
    run_stream("last_on_cw", s, 0, 1'b0);

    // Reset asserted while an item sits in ISSUE.
    busy_force = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    in_valid = 1'b1;
    in_byte = 8'h00;
    in_last = 1'b0;
    @(negedge clock);
    in_byte = 8'h78;
    @(negedge clock);
    in_valid = 1'b0;
    #2;
    check("rst_mid_issue_reached", {31'd0, data_in_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_valid_drop", {31'd0, data_in_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mid_data", {16'd0, data_in}, 32'd0);
    @(negedge clock);
    busy_force = 1'b0;
    reset = 1'b1;
    s = '{8'h40, 8'h61, 8'h00, 8'h05};
    run_stream("after_reset", s, 0, 1'b0);

    // Random streams, random valid and busy, random truncation point.
    busy_pct = 30;
    for (int r = 0; r < 10; r++) begin
      s = '{};
      ng = $urandom_range(1, 3);
      for (int g = 0; g < ng; g++) begin
        cw = 8'($urandom);
        s.push_back(cw);
        for (int k = 0; k < 8; k++) begin
          s.push_back(8'($urandom));
          if (cw[7-k]) s.push_back(8'($urandom));
        end
      end
      len = $urandom_range(1, s.size());
      while (s.size() > len) void'(s.pop_back());
      run_stream("random", s, 2, 1'b0);
    end
    busy_pct = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #600000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
